// File: rtl/neuron_relu_mac.sv
// neuron_relu_mac: hidden-layer neuron with a fixed-point MAC, ReLU activation
// and in-place SGD update of its weights and bias.
// Optional feature macro: NEURON_LEAKY_RELU_EN (leaky ReLU, adds LEAK_SHIFT).
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start, mode     pass request (accepted in IDLE), 0 = forward, 1 = backward
//   x, w, b         inputs, weights, bias (captured at acceptance)
//   dz_in, w_in     gradient and weight from the next layer
//   lr              learning rate
//   busy, done      pass in progress, one-cycle completion pulse
//   y               activated output (forward result)
//   w_out           updated {w, b}, index N is the bias (backward result)
module neuron_relu_mac #(
    parameter int N     = 6,
    parameter int BITS  = 32,
    parameter int FRAC  = 16,
    parameter int LANES = 2
`ifdef NEURON_LEAKY_RELU_EN
    ,
    parameter int LEAK_SHIFT = 3
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [N-1:0][BITS-1:0]   x,
    input  logic [N-1:0][BITS-1:0]   w,
    input  logic [BITS-1:0]          b,
    input  logic [BITS-1:0]          dz_in,
    input  logic [BITS-1:0]          w_in,
    input  logic [BITS-1:0]          lr,
    output logic                     busy,
    output logic                     done,
    output logic [BITS-1:0]          y,
    output logic [N:0][BITS-1:0]     w_out
);

    localparam int K  = (N + LANES - 1) / LANES;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int W2 = 2 * BITS;

    localparam logic signed [W2-1:0] SMAX =
        {{(BITS + 1){1'b0}}, {(BITS - 1){1'b1}}};
    localparam logic signed [W2-1:0] SMIN =
        {{(BITS + 1){1'b1}}, {(BITS - 1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        FWD_MAC,
        FWD_ACT,
        BWD_DZ,
        BWD_UPD,
        DONE
    } state_t;

    // Clamp a double-width signed value into the BITS-wide signed range.
    function automatic logic [BITS-1:0] sat(input logic signed [W2-1:0] v);
        if (v > SMAX)
            sat = SMAX[BITS-1:0];
        else if (v < SMIN)
            sat = SMIN[BITS-1:0];
        else
            sat = v[BITS-1:0];
    endfunction

    function automatic logic [BITS-1:0] sat_mul(input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] c);
        logic signed [W2-1:0] ae;
        logic signed [W2-1:0] ce;
        logic signed [W2-1:0] p;
        ae = W2'($signed(a));
        ce = W2'($signed(c));
        p  = ae * ce;
        sat_mul = sat(p >>> FRAC);
    endfunction

    function automatic logic [BITS-1:0] sat_add(input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] c);
        logic signed [W2-1:0] ae;
        logic signed [W2-1:0] ce;
        ae = W2'($signed(a));
        ce = W2'($signed(c));
        sat_add = sat(ae + ce);
    endfunction

    function automatic logic [BITS-1:0] sat_sub(input logic [BITS-1:0] a,
                                                input logic [BITS-1:0] c);
        logic signed [W2-1:0] ae;
        logic signed [W2-1:0] ce;
        ae = W2'($signed(a));
        ce = W2'($signed(c));
        sat_sub = sat(ae - ce);
    endfunction

    state_t state, nxt;

    logic [N-1:0][BITS-1:0] x_r;
    logic [N-1:0][BITS-1:0] w_r;
    logic [BITS-1:0]        b_r;
    logic [BITS-1:0]        dzin_r;
    logic [BITS-1:0]        win_r;
    logic [BITS-1:0]        lr_r;
    logic [BITS-1:0]        acc;
    logic [BITS-1:0]        act;
    logic [BITS-1:0]        dz;
    logic [CW-1:0]          grp;

    logic                       accept;
    logic                       last;
    int                         base;
    logic [LANES-1:0][BITS-1:0] lx;
    logic [LANES-1:0][BITS-1:0] lw;
    logic [LANES-1:0][BITS-1:0] lu;
    logic [BITS-1:0]            macc;
    logic [BITS-1:0]            dz_raw;
    logic [BITS-1:0]            bias_upd;

    assign accept = (state == IDLE) && start;
    assign last   = (grp == CW'(K - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    nxt = mode ? BWD_DZ : FWD_MAC;
            end
            FWD_MAC: begin
                busy = 1'b1;
                if (last)
                    nxt = FWD_ACT;
            end
            FWD_ACT: begin
                busy = 1'b1;
                nxt  = DONE;
            end
            BWD_DZ: begin
                busy = 1'b1;
                nxt  = BWD_UPD;
            end
            BWD_UPD: begin
                busy = 1'b1;
                if (last)
                    nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Lane operands are selected by group; lanes past N read zero, so the
    // padded products add nothing to the accumulator.
    always_comb begin
        base = int'(grp) * LANES;
        macc = acc;
        lx   = '0;
        lw   = '0;
        lu   = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int i = 0; i < N; i++) begin
                if (i == base + l) begin
                    lx[l] = x_r[i];
                    lw[l] = w_r[i];
                end
            end
            macc  = sat_add(macc, sat_mul(lx[l], lw[l]));
            lu[l] = sat_sub(lw[l], sat_mul(lr_r, sat_mul(dz, lx[l])));
        end
    end

    assign dz_raw   = sat_mul(win_r, dzin_r);
    assign bias_upd = sat_sub(b_r, sat_mul(lr_r, dz));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r    <= '0;
            w_r    <= '0;
            b_r    <= '0;
            dzin_r <= '0;
            win_r  <= '0;
            lr_r   <= '0;
            acc    <= '0;
            act    <= '0;
            dz     <= '0;
            grp    <= '0;
            y      <= '0;
            w_out  <= '0;
        end else begin
            if (accept) begin
                x_r    <= x;
                w_r    <= w;
                b_r    <= b;
                dzin_r <= dz_in;
                win_r  <= w_in;
                lr_r   <= lr;
                acc    <= b;
                grp    <= '0;
            end
            if (state == FWD_MAC) begin
                acc <= macc;
                grp <= grp + 1'b1;
            end
            if (state == FWD_ACT) begin
                act <= acc;
`ifdef NEURON_LEAKY_RELU_EN
                y <= ($signed(acc) > 0) ? acc
                     : BITS'($signed(acc) >>> LEAK_SHIFT);
`else
                y <= ($signed(acc) > 0) ? acc : '0;
`endif
            end
            if (state == BWD_DZ) begin
`ifdef NEURON_LEAKY_RELU_EN
                dz <= ($signed(act) > 0) ? dz_raw
                      : BITS'($signed(dz_raw) >>> LEAK_SHIFT);
`else
                dz <= ($signed(act) > 0) ? dz_raw : '0;
`endif
            end
            if (state == BWD_UPD) begin
                grp <= grp + 1'b1;
                for (int i = 0; i < N; i++) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (i == base + l)
                            w_out[i] <= lu[l];
                    end
                end
                if (grp == '0)
                    w_out[N] <= bias_upd;
            end
        end
    end

endmodule

// File: tb/tb_neuron_relu_mac.sv
// tb_neuron_relu_mac: directed and randomized checks of neuron_relu_mac
// against an arithmetic reference model of the neuron.
module tb_neuron_relu_mac;

    localparam int N     = 6;
    localparam int BITS  = 32;
    localparam int FRAC  = 16;
    localparam int LANES = 2;
    localparam int K     = (N + LANES - 1) / LANES;
    localparam int LS    = 3;

    localparam logic [15:0] EXP_BUSY = (16'd1 << (K + 2)) - 16'd2;
    localparam logic [15:0] EXP_DONE = 16'd1 << (K + 2);

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic                   mode;
    logic [N-1:0][BITS-1:0] x;
    logic [N-1:0][BITS-1:0] w;
    logic [BITS-1:0]        b;
    logic [BITS-1:0]        dz_in;
    logic [BITS-1:0]        w_in;
    logic [BITS-1:0]        lr;
    logic                   busy;
    logic                   done;
    logic [BITS-1:0]        y;
    logic [N:0][BITS-1:0]   w_out;

    int vectors;
    int errs;

    logic [BITS-1:0]      m_act;
    logic [BITS-1:0]      m_y;
    logic [N:0][BITS-1:0] m_wout;

    neuron_relu_mac #(
        .N(N), .BITS(BITS), .FRAC(FRAC), .LANES(LANES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x(x), .w(w), .b(b), .dz_in(dz_in), .w_in(w_in), .lr(lr),
        .busy(busy), .done(done), .y(y), .w_out(w_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint msat(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint mmul(input longint a, input longint c);
        return msat((a * c) >>> FRAC);
    endfunction

    // Reference: forward = bias plus ascending saturated products, then ReLU;
    // backward = gradient gated by the last activation, then SGD step.
    task automatic model_pass(input bit m);
        longint acc;
        longint dzv;
        longint t;
        if (!m) begin
            acc = sx(b);
            for (int i = 0; i < N; i++)
                acc = msat(acc + mmul(sx(x[i]), sx(w[i])));
            m_act = acc[31:0];
`ifdef NEURON_LEAKY_RELU_EN
            t = (acc > 0) ? acc : (acc >>> LS);
`else
            t = (acc > 0) ? acc : 64'sd0;
`endif
            m_y = t[31:0];
        end else begin
            dzv = mmul(sx(w_in), sx(dz_in));
`ifdef NEURON_LEAKY_RELU_EN
            if (sx(m_act) <= 0) dzv = dzv >>> LS;
`else
            if (sx(m_act) <= 0) dzv = 0;
`endif
            for (int i = 0; i < N; i++) begin
                t = msat(sx(w[i]) - mmul(sx(lr), mmul(dzv, sx(x[i]))));
                m_wout[i] = t[31:0];
            end
            t = msat(sx(b) - mmul(sx(lr), dzv));
            m_wout[N] = t[31:0];
        end
    endtask

    function automatic logic [31:0] rq();
        logic [31:0] r;
        if ($urandom_range(0, 4) == 0)
            r = $urandom;
        else
            r = 32'($urandom_range(0, 262144)) - 32'd131072;
        return r;
    endfunction

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            x[i] = rq();
            w[i] = rq();
        end
        b     = rq();
        dz_in = rq();
        w_in  = rq();
        lr    = 32'($urandom_range(1, 65536));
        mode  = 1'($urandom_range(0, 1));
    endtask

    task automatic set_all(input logic [31:0] xv, input logic [31:0] wv,
                           input logic [31:0] bv);
        for (int i = 0; i < N; i++) begin
            x[i] = xv;
            w[i] = wv;
        end
        b = bv;
    endtask

    // Runs one pass and records busy/done for cycles 1..K+5 after acceptance.
    task automatic do_pass(input bit m, input int pulse_at,
                           input bit scramble,
                           output logic [15:0] btr,
                           output logic [15:0] dtr);
        model_pass(m);
        btr = '0;
        dtr = '0;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (scramble) rand_inputs();
        for (int c = 1; c <= K + 5; c++) begin
            if (c > 1) @(negedge clk);
            start  = (c == pulse_at);
            btr[c] = busy;
            dtr[c] = done;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
        end
        vectors++;
        if (y !== '0) begin
            errs++;
            $display("FAIL reset_y got %h want 0", y);
        end
        vectors++;
        if (w_out !== '0) begin
            errs++;
            $display("FAIL reset_wout got %h want 0", w_out);
        end
        rst    = 1'b0;
        m_act  = '0;
        m_y    = '0;
        m_wout = '0;
        @(negedge clk);
    endtask

    task automatic test_bwd_no_fwd();
        logic [15:0] btr, dtr;
        logic [N-1:0][BITS-1:0] cw;
        logic [BITS-1:0] cb;
        rand_inputs();
        cw = w;
        cb = b;
        do_pass(1'b1, 0, 1'b1, btr, dtr);
        vectors++;
        if (dtr !== EXP_DONE || btr !== EXP_BUSY) begin
            errs++;
            $display("FAIL nofwd_timing busy=%h done=%h want %h %h",
                     btr, dtr, EXP_BUSY, EXP_DONE);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (w_out[i] !== cw[i]) begin
                errs++;
                $display("FAIL nofwd_w[%0d] got %h want %h", i, w_out[i], cw[i]);
            end
        end
        vectors++;
        if (w_out[N] !== cb) begin
            errs++;
            $display("FAIL nofwd_bias got %h want %h", w_out[N], cb);
        end
    endtask

    task automatic test_fwd_basic(input int pulse_at);
        logic [15:0] btr, dtr;
        set_all(32'h0001_0000, 32'h0000_8000, 32'h0);
        do_pass(1'b0, pulse_at, 1'b0, btr, dtr);
        vectors++;
        if (btr !== EXP_BUSY) begin
            errs++;
            $display("FAIL fwd_busy p=%0d got %h want %h", pulse_at, btr, EXP_BUSY);
        end
        vectors++;
        if (dtr !== EXP_DONE) begin
            errs++;
            $display("FAIL fwd_done p=%0d got %h want %h", pulse_at, dtr, EXP_DONE);
        end
        vectors++;
        if (y !== 32'h0003_0000 || y !== m_y) begin
            errs++;
            $display("FAIL fwd_y p=%0d got %h want 00030000", pulse_at, y);
        end
    endtask

    task automatic test_bwd_basic();
        logic [15:0] btr, dtr;
        set_all(32'h0001_0000, 32'h0000_8000, 32'h0);
        dz_in = 32'h0001_0000;
        w_in  = 32'h0001_0000;
        lr    = 32'h0000_4000;
        do_pass(1'b1, 0, 1'b0, btr, dtr);
        vectors++;
        if (dtr !== EXP_DONE || btr !== EXP_BUSY) begin
            errs++;
            $display("FAIL bwd_timing busy=%h done=%h want %h %h",
                     btr, dtr, EXP_BUSY, EXP_DONE);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (w_out[i] !== 32'h0000_4000) begin
                errs++;
                $display("FAIL bwd_w[%0d] got %h want 00004000", i, w_out[i]);
            end
        end
        vectors++;
        if (w_out[N] !== 32'hFFFF_C000) begin
            errs++;
            $display("FAIL bwd_bias got %h want ffffc000", w_out[N]);
        end
        vectors++;
        if (y !== 32'h0003_0000) begin
            errs++;
            $display("FAIL bwd_y_hold got %h want 00030000", y);
        end
    endtask

    task automatic test_fwd_neg();
        logic [15:0] btr, dtr;
        logic [31:0] ey;
`ifdef NEURON_LEAKY_RELU_EN
        ey = 32'hFFFF_A000;
`else
        ey = 32'h0;
`endif
        set_all(32'h0001_0000, 32'hFFFF_8000, 32'h0);
        do_pass(1'b0, 0, 1'b0, btr, dtr);
        vectors++;
        if (y !== ey) begin
            errs++;
            $display("FAIL neg_y got %h want %h", y, ey);
        end
        vectors++;
        if (w_out !== m_wout) begin
            errs++;
            $display("FAIL neg_wout_hold got %h want %h", w_out, m_wout);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] btr, dtr;
        set_all(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_FFFF);
        do_pass(1'b0, 0, 1'b0, btr, dtr);
        vectors++;
        if (y !== 32'h7FFF_FFFF) begin
            errs++;
            $display("FAIL sat_y got %h want 7fffffff", y);
        end
        set_all(32'h0001_0000, 32'h8000_0000, 32'h8000_0000);
        dz_in = 32'h7FFF_FFFF;
        w_in  = 32'h7FFF_FFFF;
        lr    = 32'h7FFF_FFFF;
        do_pass(1'b1, 0, 1'b0, btr, dtr);
        for (int i = 0; i <= N; i++) begin
            vectors++;
            if (w_out[i] !== 32'h8000_0000) begin
                errs++;
                $display("FAIL sat_w[%0d] got %h want 80000000", i, w_out[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] btr, dtr;
        bit m;
        for (int n = 0; n < 24; n++) begin
            rand_inputs();
            m = mode;
            do_pass(m, 0, 1'b1, btr, dtr);
            vectors++;
            if (dtr !== EXP_DONE || btr !== EXP_BUSY) begin
                errs++;
                $display("FAIL rnd%0d_timing busy=%h done=%h", n, btr, dtr);
            end
            vectors++;
            if (y !== m_y) begin
                errs++;
                $display("FAIL rnd%0d_y m=%0d got %h want %h", n, m, y, m_y);
            end
            for (int i = 0; i <= N; i++) begin
                vectors++;
                if (w_out[i] !== m_wout[i]) begin
                    errs++;
                    $display("FAIL rnd%0d_w[%0d] got %h want %h",
                             n, i, w_out[i], m_wout[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midpass();
        rand_inputs();
        @(negedge clk);
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL midrst_ctl busy=%b done=%b want 0 0", busy, done);
        end
        vectors++;
        if (y !== '0 || w_out !== '0) begin
            errs++;
            $display("FAIL midrst_data y=%h wout=%h want 0", y, w_out);
        end
        @(negedge clk);
        rst    = 1'b0;
        m_act  = '0;
        m_y    = '0;
        m_wout = '0;
        test_fwd_basic(0);
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        rst     = 1'b1;
        start   = 1'b0;
        mode    = 1'b0;
        x       = '0;
        w       = '0;
        b       = '0;
        dz_in   = '0;
        w_in    = '0;
        lr      = '0;
        test_reset();
        test_bwd_no_fwd();
        test_fwd_basic(0);
        test_bwd_basic();
        test_fwd_neg();
        test_saturation();
        test_fwd_basic(2);
        test_random();
        test_reset_midpass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
